// File: rtl/pipes.sv
// Execute-stage shared types: MDU sequencer states, op-field bit indices and a sign-extend helper.
package pipes;

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} mdu_state_t;

   // Bit positions inside multiplyEn {W, IS} and divideEn {W, IS, REM, UNSGN}
   localparam int MulIdxIs    = 0;
   localparam int MulIdxW     = 1;
   localparam int DivIdxUnsgn = 0;
   localparam int DivIdxRem   = 1;
   localparam int DivIdxIs    = 2;
   localparam int DivIdxW     = 3;

   function automatic logic [63:0] sext32(input logic [31:0] x);
      return {{32{x[31]}}, x};
   endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Request/response bundle between the execute stage (master) and the MDU sequencer (slave).
interface mdu_ctrl_if;

   logic        req_valid;
   logic        req_ready;
   logic [1:0]  mul_en;
   logic [3:0]  div_en;
   logic [63:0] a;
   logic [63:0] b;
   logic        flush;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_data;
   logic        busy;

   modport master (
      output req_valid, mul_en, div_en, a, b, flush, resp_ready,
      input  req_ready, resp_valid, resp_data, busy
   );

   modport slave (
      input  req_valid, mul_en, div_en, a, b, flush, resp_ready,
      output req_ready, resp_valid, resp_data, busy
   );

endinterface

// File: rtl/mdu_divider.sv
// Restoring divider on unsigned magnitudes: one quotient bit per step_i pulse, 64 or 32 steps.
module mdu_divider (
   input  logic        clk,
   input  logic        reset,
   input  logic        load_i,
   input  logic        step_i,
   input  logic        w_i,
   input  logic [63:0] dividend_i,
   input  logic [63:0] divisor_i,
   output logic [63:0] quo_nxt_o,
   output logic [63:0] rem_nxt_o
);

   logic [63:0] rem_q, rem_d;
   logic [63:0] quo_q, quo_d;
   logic [63:0] dvs_q, dvs_d;
   logic [64:0] rem_sh;
   logic [64:0] diff;

   always_comb begin
      rem_sh    = {rem_q, quo_q[63]};
      diff      = rem_sh - {1'b0, dvs_q};
      // diff[64] set means the trial subtraction went negative: restore
      quo_nxt_o = {quo_q[62:0], ~diff[64]};
      rem_nxt_o = diff[64] ? rem_sh[63:0] : diff[63:0];

      rem_d = rem_q;
      quo_d = quo_q;
      dvs_d = dvs_q;
      if (load_i) begin
         rem_d = '0;
         // W ops pre-shift the dividend so its MSB is consumed first
         quo_d = w_i ? {dividend_i[31:0], 32'b0} : dividend_i;
         dvs_d = w_i ? {32'b0, divisor_i[31:0]} : divisor_i;
      end else if (step_i) begin
         rem_d = rem_nxt_o;
         quo_d = quo_nxt_o;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
      end else begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         dvs_q <= dvs_d;
      end
   end

endmodule

// File: rtl/mdu_ctrl.sv
// RV64M mul/div sequencer: one op at a time, shift-add multiply, restoring divide, held response.
// Build option MDU_FAST_MUL_EN: single-cycle multiply that skips the MUL state.
module mdu_ctrl
   import pipes::*;
(
   input logic       clk,
   input logic       reset,
   mdu_ctrl_if.slave bus
);

   mdu_state_t  state_q, state_d;
   logic [6:0]  cnt_q, cnt_d;
   logic        w_q, w_d;
   logic        rem_q, rem_d;
   logic        q_neg_q, q_neg_d;
   logic        r_neg_q, r_neg_d;
   logic [63:0] mcand_q, mcand_d;
   logic [63:0] mplier_q, mplier_d;
   logic [63:0] prod_q, prod_d;
   logic        resp_valid_q, resp_valid_d;
   logic [63:0] resp_data_q, resp_data_d;

   logic        in_w, in_sgn, in_rem, a_neg, b_neg, div_zero, div_ovf;
   logic [63:0] a_eff, b_eff, a_mag, b_mag, sc_res;
   logic        div_load, div_step;
   logic [63:0] quo_nxt, rem_nxt, quo_fix, rem_fix, div_res, mul_sum, mul_res;

`ifdef MDU_FAST_MUL_EN
   logic [63:0] fast_prod;
   logic [31:0] fast_prod_w;
   assign fast_prod   = bus.a * bus.b;
   assign fast_prod_w = bus.a[31:0] * bus.b[31:0];
`endif

   // Divide operand decode on the incoming request
   always_comb begin
      in_w     = bus.div_en[DivIdxW];
      in_sgn   = ~bus.div_en[DivIdxUnsgn];
      in_rem   = bus.div_en[DivIdxRem];
      a_eff    = in_w ? sext32(bus.a[31:0]) : bus.a;
      b_eff    = in_w ? sext32(bus.b[31:0]) : bus.b;
      a_neg    = in_sgn & a_eff[63];
      b_neg    = in_sgn & b_eff[63];
      a_mag    = a_neg ? -a_eff : a_eff;
      b_mag    = b_neg ? -b_eff : b_eff;
      div_zero = (b_eff == '0);
      div_ovf  = in_sgn & (b_eff == '1) &
                 (in_w ? (bus.a[31:0] == 32'h8000_0000) : (bus.a == 64'h8000_0000_0000_0000));
      if (div_zero) sc_res = in_rem ? a_eff : '1;
      else          sc_res = in_rem ? '0 : a_eff;
   end

   // Final-step results, sign fixed and W-extended
   always_comb begin
      quo_fix = q_neg_q ? -quo_nxt : quo_nxt;
      rem_fix = r_neg_q ? -rem_nxt : rem_nxt;
      div_res = rem_q ? rem_fix : quo_fix;
      if (w_q) div_res = sext32(div_res[31:0]);
      mul_sum = prod_q + (mplier_q[0] ? mcand_q : '0);
      mul_res = w_q ? sext32(mul_sum[31:0]) : mul_sum;
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      w_d          = w_q;
      rem_d        = rem_q;
      q_neg_d      = q_neg_q;
      r_neg_d      = r_neg_q;
      mcand_d      = mcand_q;
      mplier_d     = mplier_q;
      prod_d       = prod_q;
      resp_valid_d = resp_valid_q;
      resp_data_d  = resp_data_q;
      div_load     = 1'b0;
      div_step     = 1'b0;

      if (bus.flush) begin
         state_d      = IDLE;
         resp_valid_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.req_valid && bus.mul_en[MulIdxIs]) begin
                  w_d = bus.mul_en[MulIdxW];
`ifdef MDU_FAST_MUL_EN
                  resp_data_d  = bus.mul_en[MulIdxW] ? sext32(fast_prod_w) : fast_prod;
                  resp_valid_d = 1'b1;
                  state_d      = DONE;
`else
                  mcand_d  = bus.mul_en[MulIdxW] ? {32'b0, bus.a[31:0]} : bus.a;
                  mplier_d = bus.mul_en[MulIdxW] ? {32'b0, bus.b[31:0]} : bus.b;
                  prod_d   = '0;
                  cnt_d    = bus.mul_en[MulIdxW] ? 7'd32 : 7'd64;
                  state_d  = MUL;
`endif
               end else if (bus.req_valid && bus.div_en[DivIdxIs]) begin
                  w_d     = in_w;
                  rem_d   = in_rem;
                  q_neg_d = a_neg ^ b_neg;
                  r_neg_d = a_neg;
                  if (div_zero || div_ovf) begin
                     resp_data_d  = sc_res;
                     resp_valid_d = 1'b1;
                     state_d      = DONE;
                  end else begin
                     div_load = 1'b1;
                     cnt_d    = in_w ? 7'd32 : 7'd64;
                     state_d  = DIV;
                  end
               end
            end
            MUL: begin
               prod_d   = mul_sum;
               mcand_d  = {mcand_q[62:0], 1'b0};
               mplier_d = {1'b0, mplier_q[63:1]};
               cnt_d    = cnt_q - 7'd1;
               if (cnt_q == 7'd1) begin
                  resp_data_d  = mul_res;
                  resp_valid_d = 1'b1;
                  state_d      = DONE;
               end
            end
            DIV: begin
               div_step = 1'b1;
               cnt_d    = cnt_q - 7'd1;
               if (cnt_q == 7'd1) begin
                  resp_data_d  = div_res;
                  resp_valid_d = 1'b1;
                  state_d      = DONE;
               end
            end
            DONE: begin
               if (bus.resp_ready) begin
                  resp_valid_d = 1'b0;
                  state_d      = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         w_q          <= 1'b0;
         rem_q        <= 1'b0;
         q_neg_q      <= 1'b0;
         r_neg_q      <= 1'b0;
         mcand_q      <= '0;
         mplier_q     <= '0;
         prod_q       <= '0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         w_q          <= w_d;
         rem_q        <= rem_d;
         q_neg_q      <= q_neg_d;
         r_neg_q      <= r_neg_d;
         mcand_q      <= mcand_d;
         mplier_q     <= mplier_d;
         prod_q       <= prod_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
      end
   end

   mdu_divider u_divider (
      .clk        (clk),
      .reset      (reset),
      .load_i     (div_load),
      .step_i     (div_step),
      .w_i        (in_w),
      .dividend_i (a_mag),
      .divisor_i  (b_mag),
      .quo_nxt_o  (quo_nxt),
      .rem_nxt_o  (rem_nxt)
   );

   assign bus.req_ready  = (state_q == IDLE);
   assign bus.busy       = (state_q != IDLE);
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_data  = resp_data_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed plan vectors plus randomized ops against a model.
module tb_mdu_ctrl;

   logic clk;
   logic reset;
   int   n_vec;
   int   n_err;

   mdu_ctrl_if bus ();

   mdu_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Architectural RV64M result
   function automatic logic [63:0] model_data(input logic [1:0] me, input logic [3:0] de,
                                              input logic [63:0] av, input logic [63:0] bv);
      logic [63:0] x, y, q, r, res;
      logic [31:0] p;
      longint      sx, sy;
      if (me[0]) begin
         if (me[1]) begin
            p = av[31:0] * bv[31:0];
            return {{32{p[31]}}, p};
         end
         return av * bv;
      end
      if (de[3]) begin
         x = de[0] ? {32'b0, av[31:0]} : {{32{av[31]}}, av[31:0]};
         y = de[0] ? {32'b0, bv[31:0]} : {{32{bv[31]}}, bv[31:0]};
      end else begin
         x = av;
         y = bv;
      end
      sx = x;
      sy = y;
      if (y == 64'd0) begin
         q = '1;
         r = x;
      end else if (!de[0] && !de[3] && x == 64'h8000_0000_0000_0000 && y == '1) begin
         q = x;
         r = '0;
      end else if (!de[0]) begin
         q = sx / sy;
         r = sx % sy;
      end else begin
         q = x / y;
         r = x % y;
      end
      res = de[1] ? r : q;
      if (de[3]) res = {{32{res[31]}}, res[31:0]};
      return res;
   endfunction

   // Cycles from accept (cycle T) to resp_valid, counted so that T+1 is 1
   function automatic int model_lat(input logic [1:0] me, input logic [3:0] de,
                                    input logic [63:0] av, input logic [63:0] bv);
      if (me[0]) begin
`ifdef MDU_FAST_MUL_EN
         return 1;
`else
         return me[1] ? 33 : 65;
`endif
      end
      if (de[3]) begin
         if (bv[31:0] == 32'd0) return 1;
         if (!de[0] && av[31:0] == 32'h8000_0000 && bv[31:0] == 32'hFFFF_FFFF) return 1;
         return 33;
      end
      if (bv == 64'd0) return 1;
      if (!de[0] && av == 64'h8000_0000_0000_0000 && bv == '1) return 1;
      return 65;
   endfunction

   // Issue one op from IDLE, wait (bounded) for the response, then take it.
   task automatic do_op(input logic [1:0] me, input logic [3:0] de, input logic [63:0] av,
                        input logic [63:0] bv, output logic [63:0] data, output int lat);
      bus.mul_en    = me;
      bus.div_en    = de;
      bus.a         = av;
      bus.b         = bv;
      bus.req_valid = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      bus.mul_en    = 2'($urandom);
      bus.div_en    = 4'($urandom);
      bus.a         = {$urandom, $urandom};
      bus.b         = {$urandom, $urandom};
      lat = 1;
      while (!bus.resp_valid && lat < 200) begin
         tick();
         lat++;
      end
      data = bus.resp_data;
      bus.resp_ready = 1'b1;
      tick();
      bus.resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      bus.req_valid  = 1'b1;
      bus.mul_en     = 2'b01;
      bus.div_en     = 4'b0100;
      bus.a          = 64'd9;
      bus.b          = 64'd3;
      bus.flush      = 1'b0;
      bus.resp_ready = 1'b0;
      reset          = 1'b1;
      repeat (3) tick();
      bus.req_valid = 1'b0;
      reset         = 1'b0;
      n_vec++;
      if (bus.req_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_req_ready: got %b, expected 1", bus.req_ready);
      end
      n_vec++;
      if (bus.busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_busy: got %b, expected 0", bus.busy);
      end
      n_vec++;
      if (bus.resp_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_resp_valid: got %b, expected 0", bus.resp_valid);
      end
      n_vec++;
      if (bus.resp_data !== 64'd0) begin
         n_err++;
         $display("FAIL reset_resp_data: got %h, expected 0", bus.resp_data);
      end
   endtask

   typedef struct {
      logic [1:0]  me;
      logic [3:0]  de;
      logic [63:0] av;
      logic [63:0] bv;
      logic [63:0] exp;
   } vec_t;

   task automatic test_directed();
      vec_t        v[10];
      logic [63:0] d;
      int          lat;
      v[0] = '{2'b00, 4'b0100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD};
      v[1] = '{2'b00, 4'b0110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF};
      v[2] = '{2'b00, 4'b0101, 64'h1234_5678, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
      v[3] = '{2'b00, 4'b0111, 64'd5, 64'd0, 64'd5};
      v[4] = '{2'b00, 4'b0100, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000};
      v[5] = '{2'b00, 4'b0110, 64'h8000_0000_0000_0000, '1, 64'd0};
      v[6] = '{2'b11, 4'b0000, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE};
      v[7] = '{2'b00, 4'b1100, 64'h1_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD};
      v[8] = '{2'b01, 4'b0100, 64'd7, 64'd0, 64'd0};
      v[9] = '{2'b00, 4'b1101, 64'h0_0000_0064, 64'h7, 64'd14};
      for (int i = 0; i < 10; i++) begin
         do_op(v[i].me, v[i].de, v[i].av, v[i].bv, d, lat);
         n_vec++;
         if (d !== v[i].exp) begin
            n_err++;
            $display("FAIL directed_data[%0d]: got %h, expected %h", i, d, v[i].exp);
         end
         n_vec++;
         if (lat != model_lat(v[i].me, v[i].de, v[i].av, v[i].bv)) begin
            n_err++;
            $display("FAIL directed_latency[%0d]: got %0d, expected %0d", i, lat,
                     model_lat(v[i].me, v[i].de, v[i].av, v[i].bv));
         end
      end
   endtask

   task automatic test_random();
      logic [1:0]  kind, me;
      logic [3:0]  de;
      logic [63:0] av, bv, d;
      int          lat;
      for (int i = 0; i < 40; i++) begin
         kind = 2'($urandom_range(0, 3));
         av   = {$urandom, $urandom};
         bv   = {$urandom, $urandom};
         case ($urandom_range(0, 7))
            0: bv = '0;
            1: bv = '1;
            2: av = 64'h8000_0000_0000_0000;
            3: begin av = 64'h8000_0000; bv = '1; end
            4: bv = 64'($urandom_range(1, 9));
            default: ;
         endcase
         if (kind[1] == 1'b0) begin
            me = {kind[0], 1'b1};
            de = 4'($urandom);
         end else begin
            me = {1'($urandom), 1'b0};
            de = {kind[0], 1'b1, 2'($urandom)};
         end
         n_vec++;
         if (bus.req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL random_ready[%0d]: got %b, expected 1", i, bus.req_ready);
         end
         do_op(me, de, av, bv, d, lat);
         n_vec++;
         if (d !== model_data(me, de, av, bv)) begin
            n_err++;
            $display("FAIL random_data[%0d] me=%b de=%b a=%h b=%h: got %h, expected %h", i, me,
                     de, av, bv, d, model_data(me, de, av, bv));
         end
         n_vec++;
         if (lat != model_lat(me, de, av, bv)) begin
            n_err++;
            $display("FAIL random_latency[%0d]: got %0d, expected %0d", i, lat,
                     model_lat(me, de, av, bv));
         end
      end
   endtask

   task automatic test_no_op();
      bus.mul_en    = 2'b10;
      bus.div_en    = 4'b1011;
      bus.a         = 64'd6;
      bus.b         = 64'd2;
      bus.req_valid = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      n_vec++;
      if (bus.busy !== 1'b0) begin
         n_err++;
         $display("FAIL no_op_busy: got %b, expected 0", bus.busy);
      end
   endtask

   task automatic test_flush();
      logic [63:0] d;
      int          lat;
      bit          seen;
      bus.mul_en    = 2'b00;
      bus.div_en    = 4'b0100;
      bus.a         = {$urandom, $urandom};
      bus.b         = 64'd3;
      bus.req_valid = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      seen          = 1'b0;
      for (int k = 1; k < 10; k++) begin
         if (bus.resp_valid) seen = 1'b1;
         tick();
      end
      n_vec++;
      if (bus.busy !== 1'b1) begin
         n_err++;
         $display("FAIL flush_busy_before: got %b, expected 1", bus.busy);
      end
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      if (bus.resp_valid) seen = 1'b1;
      n_vec++;
      if (seen !== 1'b0) begin
         n_err++;
         $display("FAIL flush_resp_valid: got %b, expected 0", seen);
      end
      n_vec++;
      if (bus.req_ready !== 1'b1) begin
         n_err++;
         $display("FAIL flush_req_ready: got %b, expected 1", bus.req_ready);
      end
      do_op(2'b01, 4'b0000, 64'd3, 64'd4, d, lat);
      n_vec++;
      if (d !== 64'd12) begin
         n_err++;
         $display("FAIL flush_mul_data: got %h, expected %h", d, 64'd12);
      end
      n_vec++;
      if (lat != model_lat(2'b01, 4'b0000, 64'd3, 64'd4)) begin
         n_err++;
         $display("FAIL flush_mul_latency: got %0d, expected %0d", lat,
                  model_lat(2'b01, 4'b0000, 64'd3, 64'd4));
      end
      // flush wins over a simultaneous accept
      bus.mul_en    = 2'b01;
      bus.req_valid = 1'b1;
      bus.flush     = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      bus.flush     = 1'b0;
      n_vec++;
      if (bus.busy !== 1'b0) begin
         n_err++;
         $display("FAIL flush_over_accept: got busy %b, expected 0", bus.busy);
      end
      // flush squashes a result already in DONE
      bus.mul_en    = 2'b00;
      bus.div_en    = 4'b0101;
      bus.b         = 64'd0;
      bus.req_valid = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      n_vec++;
      if (bus.resp_valid !== 1'b1) begin
         n_err++;
         $display("FAIL flush_done_setup: got %b, expected 1", bus.resp_valid);
      end
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      n_vec++;
      if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
         n_err++;
         $display("FAIL flush_done: got valid %b ready %b, expected valid 0 ready 1",
                  bus.resp_valid, bus.req_ready);
      end
   endtask

   task automatic test_backpressure();
      logic [63:0] av, bv, exp;
      int          lat;
      av            = {$urandom, $urandom};
      bv            = {32'd0, $urandom} | 64'd1;
      exp           = model_data(2'b00, 4'b0101, av, bv);
      bus.mul_en    = 2'b00;
      bus.div_en    = 4'b0101;
      bus.a         = av;
      bus.b         = bv;
      bus.req_valid = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      lat           = 1;
      while (!bus.resp_valid && lat < 200) begin
         tick();
         lat++;
      end
      for (int k = 0; k < 5; k++) begin
         n_vec++;
         if (bus.resp_valid !== 1'b1 || bus.busy !== 1'b1 || bus.resp_data !== exp) begin
            n_err++;
            $display("FAIL backpressure[%0d]: got valid %b busy %b data %h, expected 1 1 %h",
                     k, bus.resp_valid, bus.busy, bus.resp_data, exp);
         end
         tick();
      end
      // a request offered in the handshake cycle must not be taken
      bus.resp_ready = 1'b1;
      bus.mul_en     = 2'b01;
      bus.req_valid  = 1'b1;
      tick();
      bus.resp_ready = 1'b0;
      bus.req_valid  = 1'b0;
      n_vec++;
      if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0 || bus.resp_valid !== 1'b0) begin
         n_err++;
         $display("FAIL backpressure_release: got ready %b busy %b valid %b, expected 1 0 0",
                  bus.req_ready, bus.busy, bus.resp_valid);
      end
   endtask

   task automatic test_reset_mid();
      logic [63:0] d;
      int          lat;
      bus.mul_en    = 2'b01;
      bus.a         = {$urandom, $urandom};
      bus.b         = {$urandom, $urandom};
      bus.req_valid = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      repeat (5) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_vec++;
      if (bus.busy !== 1'b0 || bus.resp_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid_op: got busy %b valid %b, expected 0 0", bus.busy,
                  bus.resp_valid);
      end
      bus.mul_en    = 2'b00;
      bus.div_en    = 4'b0101;
      bus.b         = 64'd0;
      bus.req_valid = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      reset         = 1'b1;
      tick();
      reset = 1'b0;
      n_vec++;
      if (bus.resp_data !== 64'd0 || bus.resp_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_in_done: got data %h valid %b, expected 0 0", bus.resp_data,
                  bus.resp_valid);
      end
      do_op(2'b11, 4'b0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF, d, lat);
      n_vec++;
      if (d !== 64'd1) begin
         n_err++;
         $display("FAIL reset_then_mulw: got %h, expected %h", d, 64'd1);
      end
   endtask

   initial begin
      n_vec          = 0;
      n_err          = 0;
      bus.req_valid  = 1'b0;
      bus.mul_en     = 2'b00;
      bus.div_en     = 4'b0000;
      bus.a          = '0;
      bus.b          = '0;
      bus.flush      = 1'b0;
      bus.resp_ready = 1'b0;
      reset          = 1'b1;
      test_reset();
      test_directed();
      test_no_op();
      test_random();
      test_flush();
      test_backpressure();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Sequencer for the multi-cycle RV64M multiply/divide unit. It sits beside the ALU in the execute stage and accepts one operation at a time, decoded from `control_t.multiplyEn` / `control_t.divideEn`. It iterates the shared shift-add multiplier and restoring divider, and holds the pipeline via `busy` until the result is taken. The execute stage latches the result into `execute_data_t.alu`.

## Interface
- Parameters: none. Width fixed at 64 (`u64`).
- `clk  in  1`  clock.
- `reset  in  1`  synchronous, active-high reset.
- `req_valid  in  1`  operation offered this cycle.
- `req_ready  out  1`  high only in IDLE.
- `mul_en  in  2`  {W, is}; same encoding as `multiplyEn`.
- `div_en  in  4`  {W, is, type_rem, unsgn}; same encoding as `divideEn`.
- `a  in  64`  rs1 value.
- `b  in  64`  rs2 value.
- `flush  in  1`  squash any in-flight operation.
- `resp_valid  out  1`  result available; registered.
- `resp_ready  in  1`  consumer takes the result.
- `resp_data  out  64`  result; registered.
- `busy  out  1`  stall request to the pipeline; equals (state != IDLE).

## Operation
- States: IDLE, MUL, DIV, DONE. 7-bit down-counter `cnt`.
- **Accept** on req_valid & req_ready & !flush.
  - If `mul_en[0]`, the operation is a multiply.
  - Else if `div_en[2]`, it is a divide.
  - Else nothing happens; stay in IDLE.
  - If both are set, the multiply wins.
  - Operands and op bits are latched on accept.
- **Multiply** (MUL state): radix-2 shift-add.
  - N = 64 iterations, or N = 32 if W.
  - Result = low 64 bits of a*b.
  - W: result = sext(low 32 bits of a[31:0]*b[31:0]).
- **Divide** (DIV state): restoring division on magnitudes, one quotient bit per cycle.
  - N = 64, or N = 32 if W. W uses a[31:0] and b[31:0].
  - Sign fix-up is applied when entering DONE:
    - quotient is negated when the operand signs differ (signed ops only);
    - remainder takes the sign of the dividend.
  - W results (DIVW, DIVUW, REMW, REMUW) are sign-extended from bit 31.
- **Short-circuit** cases skip iteration: IDLE goes straight to DONE.
  - Divide by zero: quotient = all ones; remainder = dividend (sign-extended if W).
  - Signed overflow (64-bit: a = 0x8000_0000_0000_0000, b = -1; W: 0x8000_0000, -1): quotient = dividend; remainder = 0.
- **DONE**: `resp_valid` = 1 and `resp_data` is held stable.
  - On resp_ready, go to IDLE.
  - No new request is accepted in the same cycle.
- **Flush**: from any state, next state = IDLE and `resp_valid` = 0.
  - Flush has priority over accept and over resp_ready.
  - The squashed result is never presented.
- **Reset**: state = IDLE, cnt = 0, `resp_valid` = 0, `resp_data` = 0. Hence `req_ready` = 1 and `busy` = 0.
- **Reset mid-operation** behaves like flush, and also clears `resp_data`.

## Timing
- Accept at cycle T. Iteration runs T+1 .. T+N. DONE, with `resp_valid` = 1, at T+N+1:
  - 64-bit ops: response at T+65.
  - W ops: response at T+33.
- Short-circuit divide: `resp_valid` at T+1.
- Response handshake completes at the first cycle ≥ DONE entry with resp_ready = 1. IDLE and `req_ready` = 1 follow in the next cycle.
- Throughput: at best one op per N+2 cycles.
- `busy` rises at T+1 and falls in the cycle state returns to IDLE.
- `req_ready` and `busy` are decoded from state; all other outputs are registered.

## Configuration
- `MDU_FAST_MUL_EN`
  - Defined: multiply uses a single-cycle `*` product. MUL state is bypassed, so any multiply reaches DONE at T+1.
  - Undefined: iterative shift-add as above, T+65 / T+33.
- Divide behaviour is identical in both builds.

## Structure
- Package `pipes` gains:
  - `mdu_state_t` enum {IDLE, MUL, DIV, DONE};
  - bit-index constants for the `multiplyEn` / `divideEn` fields (W, IS, REM, UNSGN).
- One sub-module, `mdu_divider`: restoring-division datapath (remainder/quotient shift registers, one step per `step` pulse, W-width select).
  - `mdu_ctrl` owns the FSM, counter, multiplier, sign fix-up and handshakes.

## Test plan
- **Signed divide**: DIV, a = 0xFFFF_FFFF_FFFF_FFF9 (-7), b = 2 -> `resp_data` 0xFFFF_FFFF_FFFF_FFFD at T+65. REM with the same operands -> 0xFFFF_FFFF_FFFF_FFFF.
- **Divide by zero**: DIVU, b = 0 -> 0xFFFF_FFFF_FFFF_FFFF at T+1. REMU, a = 5, b = 0 -> 5 at T+1.
- **Signed overflow**: DIV, a = 0x8000_0000_0000_0000, b = 0xFFFF_FFFF_FFFF_FFFF -> 0x8000_0000_0000_0000 at T+1. REM with the same operands -> 0.
- **MULW**: a = 0x7FFF_FFFF, b = 2 -> 0xFFFF_FFFF_FFFF_FFFE.
  - At T+33 without `MDU_FAST_MUL_EN`; at T+1 with it.
  - DIVW, a = 0x1_FFFF_FFF9, b = 2 -> 0xFFFF_FFFF_FFFF_FFFD at T+33.
- **Flush**: DIV accepted at T, flush at T+10 -> `resp_valid` never asserts and `req_ready` = 1 at T+11. MUL 3*4 accepted at T+11 -> 12.
- **Backpressure**: resp_ready held low for 5 cycles in DONE -> `resp_valid` = 1, `resp_data` stable, `busy` = 1 throughout. After resp_ready = 1, `req_ready` = 1 in the next cycle.
